// File: rtl/store_merge_pkg.sv
// Shared encodings for the store-merge datapath: request sizes, FSM states, error codes.
package store_merge_pkg;

  localparam logic [1:0] SZ_RSVD = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WRITE,
    ERR
  } state_e;

  // Word stores must sit at offset 0; halfwords need an even offset.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic      ofs_nonzero,
                                         input logic      ofs_odd);
    is_misaligned = ((size == SZ_WORD) && ofs_nonzero) ||
                    ((size == SZ_HALF) && ofs_odd);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Replaces the byte or halfword lane(s) selected by ofs in old_word with new_data (little-endian).
module lane_merge
  import store_merge_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]             old_word,
  input  logic [DATA_W-1:0]             new_data,
  input  logic [1:0]                    size,
  input  logic [$clog2(DATA_W/8)-1:0]   ofs,
  output logic [DATA_W-1:0]             merged
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(DATA_W / 8);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (((size == SZ_BYTE) || (size == SZ_HALF)) && (OFS_W'(k) == ofs)) begin
        merged[8*k +: 8] = new_data[7:0];
      end
      if ((size == SZ_HALF) && (OFS_W'(k) == (ofs + OFS_W'(1)))) begin
        merged[8*k +: 8] = new_data[15:8];
      end
    end
    if (size == SZ_WORD) begin
      merged = new_data;
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path to data memory: direct word writes, read-modify-write for halfword/byte stores,
// with misalignment, reserved-size and read-timeout reporting.
module store_merge_unit
  import store_merge_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned OFS_W = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] merged;
  logic [1:0]        code_d;
  logic [OFS_W-1:0]  req_ofs;
  logic              accept;

  assign req_ofs = req_addr[OFS_W-1:0];
  assign accept  = req_valid && req_ready;

  lane_merge #(
    .DATA_W (DATA_W)
  ) u_lane_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .size     (size_q),
    .ofs      (ofs_q),
    .merged   (merged)
  );

  // Next-state and next-output-register values.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    ofs_d   = ofs_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    code_d  = err_code;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d = req_size;
          ofs_d  = req_ofs;
          data_d = req_data;
          addr_d = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          if (req_size == SZ_RSVD) begin
            state_d = ERR;
            code_d  = ERR_SIZE;
          end else if (is_misaligned(req_size, |req_ofs, req_ofs[0])) begin
            state_d = ERR;
            code_d  = ERR_MISALIGN;
          end else if (req_size == SZ_WORD) begin
            state_d = WRITE;
            wdata_d = req_data;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          wdata_d = merged;
          state_d = WRITE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          state_d = ERR;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      size_q    <= SZ_RSVD;
      ofs_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      ofs_q     <= ofs_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == IDLE);
      mem_rd    <= (state_d == RD_REQ);
      mem_wr    <= (state_d == WRITE);
      done      <= (state_d == WRITE);
      err       <= (state_d == ERR);
      err_code  <= code_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: 32-bit instance (RD_TIMEOUT=4) and a 64-bit instance.
module tb_store_merge_unit;
  import store_merge_pkg::*;

  typedef struct {
    int          id;
    bit          is_err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  code;
    int          lat;
    int          rd;
    int          acc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t expq[$];
  int   rd_cnt[2] = '{0, 0};
  int   rsp_dly[2] = '{0, 0};
  logic [63:0] rsp_data[2];

  logic        a_valid, a_ready, a_rd, a_rvalid, a_wr, a_done, a_err;
  logic [1:0]  a_size, a_code;
  logic [31:0] a_addr, a_maddr, a_data, a_rdata, a_wdata;

  logic        b_valid, b_ready, b_rd, b_rvalid, b_wr, b_done, b_err;
  logic [1:0]  b_size, b_code;
  logic [31:0] b_addr, b_maddr;
  logic [63:0] b_data, b_rdata, b_wdata;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RD_TIMEOUT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_size(a_size), .req_addr(a_addr), .req_data(a_data), .mem_addr(a_maddr),
    .mem_rd(a_rd), .mem_rdata(a_rdata), .mem_rvalid(a_rvalid), .mem_wr(a_wr),
    .mem_wdata(a_wdata), .done(a_done), .err(a_err), .err_code(a_code)
  );

  store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RD_TIMEOUT(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_size(b_size), .req_addr(b_addr), .req_data(b_data), .mem_addr(b_maddr),
    .mem_rd(b_rd), .mem_rdata(b_rdata), .mem_rvalid(b_rvalid), .mem_wr(b_wr),
    .mem_wdata(b_wdata), .done(b_done), .err(b_err), .err_code(b_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the oldest expectation and compares one observed write/error event against it.
  task automatic check_evt(input int id, input logic wr, input logic er, input logic dn,
                           input logic [63:0] a, input logic [63:0] d, input logic [1:0] c);
    exp_t e;
    if (expq.size() == 0 || expq[0].id != id) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output dut%0d: got wr=%0b err=%0b expected no event", id, wr, er);
      rd_cnt[id] = 0;
      return;
    end
    e = expq.pop_front();
    chk($sformatf("dut%0d_kind", id), 64'({wr, er}), e.is_err ? 64'd1 : 64'd2);
    chk($sformatf("dut%0d_done", id), 64'(dn), e.is_err ? 64'd0 : 64'd1);
    chk($sformatf("dut%0d_latency", id), 64'(cyc - e.acc + 1), 64'(e.lat));
    chk($sformatf("dut%0d_rd_count", id), 64'(rd_cnt[id]), 64'(e.rd));
    if (e.is_err) begin
      chk($sformatf("dut%0d_err_code", id), 64'(c), 64'(e.code));
    end else begin
      chk($sformatf("dut%0d_mem_addr", id), a, e.addr);
      chk($sformatf("dut%0d_mem_wdata", id), d, e.wdata);
    end
    rd_cnt[id] = 0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) rd_cnt[0] = 0;
    else begin
      if (a_rd) rd_cnt[0]++;
      if (a_wr || a_err) check_evt(0, a_wr, a_err, a_done, 64'(a_maddr), 64'(a_wdata), a_code);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) rd_cnt[1] = 0;
    else begin
      if (b_rd) rd_cnt[1]++;
      if (b_wr || b_err) check_evt(1, b_wr, b_err, b_done, 64'(b_maddr), b_wdata, b_code);
    end
  end

  // Memory models: answer a read strobe after rsp_dly cycles (0 = never).
  initial begin
    a_rvalid = 1'b0;
    a_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && a_rd && rsp_dly[0] > 0) begin
        repeat (rsp_dly[0]) @(posedge clk);
        #1 a_rvalid = 1'b1;
        a_rdata = rsp_data[0][31:0];
        @(posedge clk);
        #1 a_rvalid = 1'b0;
      end
    end
  end

  initial begin
    b_rvalid = 1'b0;
    b_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && b_rd && rsp_dly[1] > 0) begin
        repeat (rsp_dly[1]) @(posedge clk);
        #1 b_rvalid = 1'b1;
        b_rdata = rsp_data[1];
        @(posedge clk);
        #1 b_rvalid = 1'b0;
      end
    end
  end

  task automatic send(input int id, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [63:0] data, input int dly, input logic [63:0] rdata,
                      input bit push, input bit is_err, input logic [63:0] eaddr,
                      input logic [63:0] ewdata, input logic [1:0] ecode,
                      input int lat, input int rd, output int acc);
    int n = 0;
    exp_t e;
    acc = 0;
    @(negedge clk);
    while (!((id == 0) ? a_ready : b_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_wait dut%0d: got req_ready=0 for 50 cycles expected 1", id);
      return;
    end
    rsp_dly[id]  = dly;
    rsp_data[id] = rdata;
    if (id == 0) begin
      a_valid = 1'b1; a_size = sz; a_addr = addr; a_data = data[31:0];
    end else begin
      b_valid = 1'b1; b_size = sz; b_addr = addr; b_data = data;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      e = '{id: id, is_err: is_err, addr: eaddr, wdata: ewdata, code: ecode,
            lat: lat, rd: rd, acc: acc};
      expq.push_back(e);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(a_ready), 64'd1);
    chk({tag, "_mem_rd"},    64'(a_rd), 64'd0);
    chk({tag, "_mem_wr"},    64'(a_wr), 64'd0);
    chk({tag, "_done"},      64'(a_done), 64'd0);
    chk({tag, "_err"},       64'(a_err), 64'd0);
    chk({tag, "_err_code"},  64'(a_code), 64'd0);
    chk({tag, "_mem_addr"},  64'(a_maddr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(a_wdata), 64'd0);
    chk({tag, "_b_wdata"},   b_wdata, 64'd0);
  endtask

  initial begin
    int acc1, acc2, n;
    reset_n = 1'b0;
    a_valid = 1'b0; a_size = '0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_size = '0; b_addr = '0; b_data = '0;
    rsp_data[0] = '0;
    rsp_data[1] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_init");
    reset_n = 1'b1;

    // 32-bit instance
    send(0, SZ_WORD, 32'h100, 64'hDEADBEEF, 0, 64'h0, 1, 0, 64'h100, 64'hDEADBEEF, 2'b00, 1, 0, acc1);
    send(0, SZ_BYTE, 32'h102, 64'hAB, 2, 64'h11223344, 1, 0, 64'h100, 64'h11AB3344, 2'b00, 4, 1, acc1);
    send(0, SZ_HALF, 32'h202, 64'hCAFE, 1, 64'h55667788, 1, 0, 64'h200, 64'hCAFE7788, 2'b00, 3, 1, acc1);
    send(0, SZ_HALF, 32'h203, 64'h1234, 0, 64'h0, 1, 1, 64'h0, 64'h0, 2'b01, 1, 0, acc1);
    send(0, 2'b00, 32'h300, 64'h0, 0, 64'h0, 1, 1, 64'h0, 64'h0, 2'b10, 1, 0, acc1);
    repeat (3) @(negedge clk);
    chk("err_code_held", 64'(a_code), 64'h2);
    send(0, SZ_BYTE, 32'h301, 64'h12, 0, 64'h0, 1, 1, 64'h0, 64'h0, 2'b11, 6, 1, acc1);
    send(0, SZ_BYTE, 32'h103, 64'h5A, 1, 64'hA0B0C0D0, 1, 0, 64'h100, 64'h5AB0C0D0, 2'b00, 3, 1, acc1);
    send(0, SZ_HALF, 32'h100, 64'h12345678, 3, 64'hFFFFFFFF, 1, 0, 64'h100, 64'hFFFF5678, 2'b00, 5, 1, acc1);
    send(0, SZ_WORD, 32'h102, 64'h0, 0, 64'h0, 1, 1, 64'h0, 64'h0, 2'b01, 1, 0, acc1);
    send(0, SZ_WORD, 32'h40, 64'hA5A5A5A5, 0, 64'h0, 1, 0, 64'h40, 64'hA5A5A5A5, 2'b00, 1, 0, acc1);
    send(0, SZ_WORD, 32'h44, 64'h5A5A5A5A, 0, 64'h0, 1, 0, 64'h44, 64'h5A5A5A5A, 2'b00, 1, 0, acc2);
    chk("back_to_back_gap", 64'(acc2 - acc1), 64'd2);

    // 64-bit instance
    send(1, SZ_BYTE, 32'h105, 64'hEE, 1, 64'h0123456789ABCDEF, 1, 0, 64'h100, 64'h0123EE6789ABCDEF, 2'b00, 3, 1, acc1);
    send(1, SZ_HALF, 32'h10E, 64'hBEEF, 2, 64'h0123456789ABCDEF, 1, 0, 64'h108, 64'hBEEF456789ABCDEF, 2'b00, 4, 1, acc1);
    send(1, SZ_WORD, 32'h108, 64'hFEDCBA9876543210, 0, 64'h0, 1, 0, 64'h108, 64'hFEDCBA9876543210, 2'b00, 1, 0, acc1);
    send(1, SZ_WORD, 32'h10C, 64'h0, 0, 64'h0, 1, 1, 64'h0, 64'h0, 2'b01, 1, 0, acc1);

    // Reset during RD_WAIT; the read data then arrives late and must be ignored.
    repeat (4) @(negedge clk);
    send(0, SZ_BYTE, 32'h104, 64'h77, 4, 64'hCCCCCCCC, 0, 0, 64'h0, 64'h0, 2'b00, 0, 0, acc1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_wdata", 64'(a_wdata), 64'd0);
    send(0, SZ_BYTE, 32'h104, 64'h77, 1, 64'hCCCCCCCC, 1, 0, 64'h104, 64'hCCCCCC77, 2'b00, 3, 1, acc1);

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Sequential, parametrised successor to the store-size datapath. It accepts a store request (size, byte address, register data) and performs the memory transaction. Full-word stores are written directly. Halfword and byte stores do a read-modify-write: memory is read, the addressed lane is replaced, and the merged word is written back. The unit sits between the control unit's store path and the data memory port. Misaligned stores, reserved sizes and memory read timeouts are flagged.

## Interface
Parameters:
- DATA_W, 32, memory word width; multiple of 8, at least 16
- ADDR_W, 32, byte address width
- RD_TIMEOUT, 16, maximum cycles spent waiting for mem_rvalid; at least 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept a request
- req_size  in  2  01 word, 10 halfword, 11 byte, 00 reserved
- req_addr  in  ADDR_W  byte address of the store
- req_data  in  DATA_W  store data; the low bits are significant for sub-word stores
- mem_addr  out  ADDR_W  word-aligned address: req_addr with offset bits cleared
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  read data valid
- mem_wr  out  1  one-cycle write strobe
- mem_wdata  out  DATA_W  write data
- done  out  1  one-cycle pulse when a store completes successfully
- err  out  1  one-cycle error pulse
- err_code  out  2  01 misaligned, 10 reserved size, 11 read timeout; held until the next err pulse

## Operation
- OFS_W = log2(DATA_W/8). The byte offset is req_addr[OFS_W-1:0]. Lane k occupies bits [8k+7:8k] (little-endian).
- Handshake: a request is accepted when req_valid and req_ready are both high. req_ready is high only in IDLE. On acceptance, latch size, address, data and offset.
- FSM states: IDLE, RD_REQ, RD_WAIT, WRITE, ERR.
- Transitions from IDLE on accept:
  - reserved size goes to ERR with code 10;
  - word with offset ≠ 0, or halfword with odd offset, goes to ERR with code 01;
  - word goes to WRITE with mem_wdata = req_data;
  - halfword or byte goes to RD_REQ.
- RD_REQ: mem_rd = 1 for exactly one cycle, then go to RD_WAIT and clear the timeout counter.
- RD_WAIT: if mem_rvalid, latch the merged word and go to WRITE.
  - Byte merge replaces lane ofs with req_data[7:0].
  - Halfword merge replaces lanes ofs and ofs+1 with req_data[15:0].
  - All other lanes come from mem_rdata.
  - Otherwise increment the counter. After RD_TIMEOUT cycles in RD_WAIT without mem_rvalid, go to ERR with code 11 and perform no write.
- WRITE: mem_wr = 1 and done = 1 for one cycle, then go to IDLE.
- ERR: err = 1 for one cycle, err_code is updated, then go to IDLE. No memory strobe is issued.
- mem_rvalid is ignored outside RD_WAIT.
- mem_addr is held stable from RD_REQ through WRITE.

## Timing
- Reset values (async assert, sync deassert):
  - state = IDLE
  - req_ready = 1
  - mem_rd = mem_wr = done = err = 0
  - err_code = 00
  - mem_addr = 0
  - mem_wdata = 0
- Word store: accept at edge T0; WRITE (mem_wr, done) in cycle T1. Latency 1.
- Sub-word store, minimum: RD_REQ in T1, RD_WAIT with mem_rvalid in T2, WRITE in T3. Latency 3 + read wait cycles.
- Error: err in T1 (misaligned or reserved size), or RD_TIMEOUT cycles after entering RD_WAIT (timeout).
- Back-to-back: the next request can be accepted in the cycle after WRITE or ERR, when IDLE is re-entered.
- A reset asserted mid-operation aborts immediately. No mem_wr is issued for the aborted store.

## Structure
- Package store_merge_pkg holds:
  - size encodings (SZ_WORD 01, SZ_HALF 10, SZ_BYTE 11);
  - the state enum;
  - error codes (ERR_MISALIGN 01, ERR_SIZE 10, ERR_TIMEOUT 11).
- One sub-module, lane_merge (combinational, parametrised by DATA_W). Inputs: old word, new data, size, offset. Output: merged word. Reusable by the load path.
- Top level: FSM, request/address registers, timeout counter.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF → T1 shows mem_wr = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF, done = 1. No mem_rd is issued.
- Byte store: addr 0x102, data 0x000000AB, mem_rdata 0x11223344 returned 2 cycles after mem_rd → mem_wdata = 0x11AB3344, and mem_wr fires one cycle after mem_rvalid.
- Halfword store: addr 0x202, data 0x0000CAFE, rdata 0x55667788 → mem_wdata = 0xCAFE7788. Then halfword to 0x203 → err = 1, err_code = 01, no mem_rd and no mem_wr.
- Reserved size 00 → err with code 10 in T1. With RD_TIMEOUT = 4 and mem_rvalid never asserted → err with code 11 exactly 4 cycles after RD_WAIT is entered, and no write.
- Reset_n pulled low during RD_WAIT → all outputs return to reset values immediately. A late mem_rvalid after release is ignored, and no write occurs.
- Parametrised DATA_W = 64: byte store to offset 5, data 0xEE → only bits [47:40] change in mem_wdata.
